// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types, sizes and expected-data rule for the memory BIST controller
package mem_bist_pkg;
    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;
    localparam int DEPTH = 2 ** MEM_ADDR_W;
    localparam int TEST_CLR = 0;
    localparam int TEST_AEQ = 1;
    typedef enum logic [2:0] {IDLE, CLR_WR, CLR_RD, CLR_DRN, AEQ_WR, AEQ_RD, AEQ_DRN, DONE} state_t;
    // Clear phase expects zero; data-equals-address phase expects the zero-extended address.
    function automatic logic [31:0] exp_data(input logic aeq, input logic [31:0] addr);
        return aeq ? addr : 32'd0;
    endfunction
endpackage

// File: rtl/mem_bist_cmp.sv
// mem_bist_cmp: one-cycle read-valid/address delay and read-data comparator
module mem_bist_cmp
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_vld,
    input  logic              rd_aeq,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mismatch,
    output logic [ADDR_W-1:0] cmp_addr,
    output logic [DATA_W-1:0] cmp_data
);
    logic              vld_q;
    logic              aeq_q;
    logic [ADDR_W-1:0] addr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            aeq_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            // A mismatch discards the read still in flight behind it.
            vld_q  <= rd_vld && !mismatch;
            aeq_q  <= rd_aeq;
            addr_q <= rd_addr;
        end
    end
    assign mismatch = vld_q && (rd_data != DATA_W'(exp_data(aeq_q, 32'(addr_q))));
    assign cmp_addr = addr_q;
    assign cmp_data = rd_data;
endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: two-phase march BIST sequencer (clear/verify-zero, data=address/verify)
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        tests,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out
);
    state_t            state, next_state;
    logic [ADDR_W-1:0] cnt, next_cnt;
    logic              aeq_en, next_aeq_en;
    logic              last, accept, mismatch;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_data;
    assign last   = cnt == '1;
    assign accept = state == IDLE && start;
    mem_bist_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp (
        .clk(clk),
        .rst(rst),
        .rd_vld(mem_read),
        .rd_aeq(state == AEQ_RD),
        .rd_addr(mem_addr),
        .rd_data(mem_data_out),
        .mismatch(mismatch),
        .cmp_addr(cmp_addr),
        .cmp_data(cmp_data)
    );
    always_comb begin
        next_state  = state;
        next_cnt    = cnt + 1'b1;
        next_aeq_en = aeq_en;
        case (state)
            IDLE: begin
                next_cnt = '0;
                if (start) begin
                    next_aeq_en = tests[TEST_AEQ];
                    next_state  = tests == 2'b00 ? DONE : tests[TEST_CLR] ? CLR_WR : AEQ_WR;
                end
            end
            CLR_WR:  next_state = last ? CLR_RD : CLR_WR;
            CLR_RD:  next_state = last ? CLR_DRN : CLR_RD;
            CLR_DRN: begin
                next_cnt   = '0;
                next_state = aeq_en ? AEQ_WR : DONE;
            end
            AEQ_WR:  next_state = last ? AEQ_RD : AEQ_WR;
            AEQ_RD:  next_state = last ? AEQ_DRN : AEQ_RD;
            AEQ_DRN: begin
                next_cnt   = '0;
                next_state = DONE;
            end
            default: begin
                next_cnt   = '0;
                next_state = IDLE;
            end
        endcase
        if (mismatch) next_state = DONE;
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            aeq_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            aeq_en      <= next_aeq_en;
            busy        <= !(next_state inside {IDLE, DONE});
            done        <= next_state == DONE;
            mem_addr    <= next_cnt;
            mem_data_in <= DATA_W'(exp_data(next_state == AEQ_WR, 32'(next_cnt)));
            mem_write   <= next_state inside {CLR_WR, AEQ_WR};
            mem_read    <= next_state inside {CLR_RD, AEQ_RD};
            if (accept) begin
                pass      <= tests == 2'b00;
                fail_addr <= '0;
                fail_data <= '0;
            end else if (mismatch) begin
                pass      <= 1'b0;
                fail_addr <= cmp_addr;
                fail_data <= cmp_data;
            end else if (next_state == DONE) begin
                pass      <= 1'b1;
            end
        end
    end
endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Hardware built-in self-test controller for the 32×8 synchronous test memory. It takes over the memory's command port (addr, data_in, read, write) and runs two march phases back to back: clear/verify-zero, then data-equals-address/verify. It reports pass/fail and captures the first failing address and data, replacing the software clear and data-equals-address routines with a synthesizable sequencer.

## Interface
- ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W
- DATA_W, 8, memory data width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin; honored only in IDLE
- tests  in  2  phase enable, sampled with start: bit0 clear phase, bit1 data=address phase
- busy  out  1  high from the cycle after start is accepted through the last compare
- done  out  1  one-cycle pulse when the run ends (pass or fail)
- pass  out  1  result of the last run; held until the next accepted start
- fail_addr  out  ADDR_W  address of first mismatch; 0 if none
- fail_data  out  DATA_W  data read at fail_addr; 0 if none
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_data_out  in  DATA_W  memory read data; valid the cycle after a read strobe

## Operation
- States: IDLE, CLR_WR, CLR_RD, CLR_DRN, AEQ_WR, AEQ_RD, AEQ_DRN, DONE.
- IDLE + start: latch tests. If tests==0, go to DONE with pass=1. Otherwise go to the first enabled phase's WR state, clear pass, fail_addr and fail_data, and set busy.
- WR states: one write per cycle, addr 0..DEPTH-1. Data is 0 in CLR and addr zero-extended to DATA_W in AEQ. mem_read=0. The last address moves to the matching RD state.
- RD states: one read per cycle, addr 0..DEPTH-1, mem_write=0. A one-cycle-delayed valid/address pipeline compares mem_data_out against the expected value for the address read in the previous cycle.
- DRN states: no strobes; compare the final address (DEPTH-1). Then go to AEQ_WR if enabled and not yet run, otherwise to DONE.
- Mismatch on any compare cycle:
  - capture fail_addr/fail_data and set pass=0;
  - next state is DONE, and strobes drop the next cycle;
  - any in-flight read result is discarded.
- DONE: done=1 for one cycle; busy=0; pass=1 if no mismatch occurred; then go to IDLE.
- start outside IDLE is ignored. tests changes while busy are ignored.
- Counter wraps DEPTH-1→0 only on a phase change. The address counter is exactly ADDR_W bits.

## Timing
- All outputs are registered. Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_data=0, mem_addr=0, mem_data_in=0, mem_read=0, mem_write=0.
- Reset mid-run: the cycle after the rst edge, all strobes are 0, state is IDLE, and no done pulse is issued.
- start accepted at edge T: first write strobe is visible in cycle T+1.
- Per enabled phase: DEPTH write cycles, DEPTH read cycles, 1 drain cycle. For DEPTH=32, that is 65 cycles.
- Both phases passing: writes in cycles 1–32, reads 33–64, drain 65, writes 66–97, reads 98–129, drain 130, done=1 in cycle 131 (relative to T+1 = cycle 1).
- Read issued in cycle n: data is compared in cycle n+1. A mismatch in compare cycle c gives done=1 in cycle c+1.
- busy falls in the same cycle that done rises.

## Structure
- Package mem_bist_pkg holds:
  - the state_t enum;
  - DEPTH derivation;
  - TEST_CLR=0 and TEST_AEQ=1 bit indices;
  - the expected-data function for each phase.
- One natural sub-module, mem_bist_cmp: a read-valid/address delay register plus the comparator, outputting mismatch, addr and data.
- The top level holds the FSM, address counter and result registers.

## Test plan
- tests=2'b11, fault-free 32×8 memory model, start pulse → 32 writes of 0, 32 reads, 32 writes of data=addr, 32 reads; done in cycle 131, pass=1, fail_addr=0.
- tests=2'b10, memory bit 3 stuck-at-0 at address 12 → first mismatch at addr 12; fail_addr=12, fail_data=8'h04; done the cycle after the compare; pass=0; no strobes after it.
- tests=2'b01, address 31 bit 0 stuck-at-1 → mismatch detected in the drain cycle (cycle 65); fail_addr=31, fail_data=8'h01; done in cycle 66.
- tests=2'b00, start → done in cycle 1, pass=1, no memory strobes.
- tests=2'b11, assert rst in cycle 40 → all outputs 0 next cycle, no done pulse. A second start in cycle 45 runs cleanly to pass=1. A start pulse in cycle 50 while busy is ignored.
